// File: rtl/otter_mmio_pkg.sv
// -----------------------------------------------------------------------------
// otter_mmio_pkg
// Shared definitions for the OTTER MMIO controller:
//   - default base addresses for the input and output register banks
//   - decode result enum/struct and the address decode helper
//   - PEND / MASK address helpers (they sit directly after the output bank)
// -----------------------------------------------------------------------------
package otter_mmio_pkg;

    localparam logic [31:0] DEF_IN_BASE  = 32'h1100_0000;
    localparam logic [31:0] DEF_OUT_BASE = 32'h1100_C000;

    typedef enum logic [2:0] {
        DEC_IN   = 3'd0,
        DEC_OUT  = 3'd1,
        DEC_PEND = 3'd2,
        DEC_MASK = 3'd3,
        DEC_NONE = 3'd4
    } dec_kind_e;

    typedef struct packed {
        dec_kind_e  kind;
        logic [2:0] idx;   // port index for DEC_IN / DEC_OUT
    } dec_t;

    function automatic logic [31:0] pend_addr(input logic [31:0] out_base,
                                              input int          n_out);
        return out_base + 32'(4 * n_out);
    endfunction

    function automatic logic [31:0] mask_addr(input logic [31:0] out_base,
                                              input int          n_out);
        return out_base + 32'(4 * (n_out + 1));
    endfunction

    // Offsets are computed with unsigned wrap-around: an address below a base
    // becomes a huge offset and simply fails the range test.
    function automatic dec_t decode(input logic [31:0] addr,
                                    input logic [31:0] in_base,
                                    input logic [31:0] out_base,
                                    input int          n_in,
                                    input int          n_out);
        dec_t        r;
        logic [31:0] off_in;
        logic [31:0] off_out;
        off_in  = addr - in_base;
        off_out = addr - out_base;
        r.kind  = DEC_NONE;
        r.idx   = '0;
        if (addr[1:0] != 2'b00) begin
            r.kind = DEC_NONE;
        end else if (off_in < 32'(4 * n_in)) begin
            r.kind = DEC_IN;
            r.idx  = off_in[4:2];
        end else if (off_out < 32'(4 * n_out)) begin
            r.kind = DEC_OUT;
            r.idx  = off_out[4:2];
        end else if (addr == pend_addr(out_base, n_out)) begin
            r.kind = DEC_PEND;
        end else if (addr == mask_addr(out_base, n_out)) begin
            r.kind = DEC_MASK;
        end
        return r;
    endfunction

endpackage

// File: rtl/otter_debounce.sv
// -----------------------------------------------------------------------------
// otter_debounce
// Single-bit debouncer. The output follows the input only after the input has
// differed from the output for DB_CYCLES consecutive cycles; any return to the
// output value restarts the count.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (output and count cleared)
//   din    in   already-synchronised input bit
//   dout   out  debounced bit
// -----------------------------------------------------------------------------
module otter_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (din != dout_q) begin
            // The current cycle is the (cnt_q+1)-th consecutive differing one.
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                dout_d = din;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/otter_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// otter_mmio_ctrl
// Memory-mapped I/O controller between the OTTER IOBUS and board pins:
// N_IN synchronised input ports, N_OUT read-back output registers, and an
// edge-triggered interrupt block (pending + mask) driving irq.
// Optional debounce of the IRQ source bits: define OTTER_MMIO_DEBOUNCE_EN.
//
// Bus handshake: IOBUS_WR / IOBUS_RD are single-cycle strobes accepted every
// cycle (no busy state). A write commits at the strobe edge. A read strobe in
// cycle t loads IOBUS_IN at the end of t and pulses IOBUS_RDY in t+1 only;
// IOBUS_IN then holds until the next read. RD+WR together return pre-write data.
//
// Ports:
//   CLK, RESET_N          clock, synchronous active-low reset
//   IOBUS_ADDR/OUT/WR/RD  bus request from the MCU
//   IOBUS_IN, IOBUS_RDY   registered read data and its valid pulse
//   in_ports              asynchronous board inputs, port k = [k*PORT_W +: PORT_W]
//   out_ports             registered board outputs
//   irq                   registered |(pending & mask)
// -----------------------------------------------------------------------------
module otter_mmio_ctrl
    import otter_mmio_pkg::*;
#(
    parameter logic [31:0] IN_BASE   = DEF_IN_BASE,
    parameter logic [31:0] OUT_BASE  = DEF_OUT_BASE,
    parameter int          N_IN      = 4,
    parameter int          N_OUT     = 4,
    parameter int          PORT_W    = 16,
    parameter int          IRQ_W     = 5,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [31:0]              IOBUS_ADDR,
    input  logic [31:0]              IOBUS_OUT,
    input  logic                     IOBUS_WR,
    input  logic                     IOBUS_RD,
    output logic [31:0]              IOBUS_IN,
    output logic                     IOBUS_RDY,
    input  logic [N_IN*PORT_W-1:0]   in_ports,
    output logic [N_OUT*PORT_W-1:0]  out_ports,
    output logic                     irq
);

    logic [N_IN*PORT_W-1:0]  sync1_q, sync1_d;
    logic [N_IN*PORT_W-1:0]  sync2_q, sync2_d;
    logic [IRQ_W-1:0]        src_prev_q, src_prev_d;
    logic [IRQ_W-1:0]        pending_q, pending_d;
    logic [IRQ_W-1:0]        mask_q, mask_d;
    logic [N_OUT*PORT_W-1:0] out_q, out_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rdy_q, rdy_d;
    logic                    irq_q, irq_d;

    logic [IRQ_W-1:0]        src_val;   // IRQ source bits as seen by edge detect and reads
    logic [N_IN*PORT_W-1:0]  in_view;   // input ports as returned on the bus
    logic [IRQ_W-1:0]        rise;
    logic [IRQ_W-1:0]        pend_clr;
    logic [31:0]             rd_word;
    dec_t                    dec;
    logic                    unused_wdata;

    // Only the low PORT_W / IRQ_W bits of the write data are stored.
    assign unused_wdata = ^IOBUS_OUT;

`ifdef OTTER_MMIO_DEBOUNCE_EN
    for (genvar i = 0; i < IRQ_W; i++) begin : g_db
        otter_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk  (CLK),
            .rst_n(RESET_N),
            .din  (sync2_q[i]),
            .dout (src_val[i])
        );
    end
`else
    assign src_val = sync2_q[IRQ_W-1:0];
`endif

    always_comb begin
        in_view              = sync2_q;
        in_view[IRQ_W-1:0]   = src_val;
    end

    always_comb begin
        dec        = decode(IOBUS_ADDR, IN_BASE, OUT_BASE, N_IN, N_OUT);
        sync1_d    = in_ports;
        sync2_d    = sync1_q;
        src_prev_d = src_val;
        rise       = src_val & ~src_prev_q;
        out_d      = out_q;
        mask_d     = mask_q;
        pend_clr   = '0;

        if (IOBUS_WR) begin
            case (dec.kind)
                DEC_OUT: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (dec.idx == 3'(k)) begin
                            out_d[k*PORT_W +: PORT_W] = IOBUS_OUT[PORT_W-1:0];
                        end
                    end
                end
                DEC_PEND: pend_clr = IOBUS_OUT[IRQ_W-1:0];
                DEC_MASK: mask_d   = IOBUS_OUT[IRQ_W-1:0];
                default:  ;
            endcase
        end

        // Set has priority over a same-cycle write-1-to-clear.
        pending_d = (pending_q & ~pend_clr) | rise;
        irq_d     = |(pending_q & mask_q);

        // Read mux uses current register values, so RD+WR returns pre-write data.
        rd_word = '0;
        case (dec.kind)
            DEC_IN: begin
                for (int k = 0; k < N_IN; k++) begin
                    if (dec.idx == 3'(k)) begin
                        rd_word[PORT_W-1:0] = in_view[k*PORT_W +: PORT_W];
                    end
                end
            end
            DEC_OUT: begin
                for (int k = 0; k < N_OUT; k++) begin
                    if (dec.idx == 3'(k)) begin
                        rd_word[PORT_W-1:0] = out_q[k*PORT_W +: PORT_W];
                    end
                end
            end
            DEC_PEND: rd_word[IRQ_W-1:0] = pending_q;
            DEC_MASK: rd_word[IRQ_W-1:0] = mask_q;
            default:  rd_word = '0;
        endcase

        rd_data_d = IOBUS_RD ? rd_word : rd_data_q;
        rdy_d     = IOBUS_RD;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            src_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            out_q      <= '0;
            rd_data_q  <= '0;
            rdy_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            out_q      <= out_d;
            rd_data_q  <= rd_data_d;
            rdy_q      <= rdy_d;
            irq_q      <= irq_d;
        end
    end

    assign IOBUS_IN  = rd_data_q;
    assign IOBUS_RDY = rdy_q;
    assign out_ports = out_q;
    assign irq       = irq_q;

endmodule
